// File: rtl/av_posted_write_bridge_pkg.sv
// Shared definitions for the posted-write Avalon bridge: default widths
// and the read-sequencing state encoding.
package av_posted_write_bridge_pkg;

    localparam int DEF_WR_FIFO_DEPTH = 4;
    localparam int DEF_ADDR_W        = 30;
    localparam int DEF_DATA_W        = 32;
    localparam int DEF_BE_W          = DEF_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_DRAIN = 2'd1,
        RD_ISSUE = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/av_posted_write_bridge_wr_fifo.sv
// Synchronous posted-write FIFO. The head entry and the one behind it are read
// straight out of the storage registers so the bridge can present either.
module av_wr_fifo
    import av_posted_write_bridge_pkg::*;
#(
    parameter int DEPTH = DEF_WR_FIFO_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_BE_W + DEF_DATA_W
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic [WIDTH-1:0]       next_head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even when the head leaves in the same cycle.
    assign full       = (count == DEPTH_C);
    assign empty      = (count == '0);
    assign do_push    = push & ~full;
    assign do_pop     = pop & ~empty;
    assign rd_ptr_inc = rd_ptr + PTR_W'(1);

    assign head_data      = mem[rd_ptr];
    assign next_head_data = mem[rd_ptr_inc];

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_inc;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/av_posted_write_bridge.sv
// Avalon bridge that posts writes into a FIFO and holds reads until every
// earlier write has left; idle upstream outputs are 0 for crossbar OR-ing.
module av_posted_write_bridge
    import av_posted_write_bridge_pkg::*;
#(
    parameter int WR_FIFO_DEPTH = DEF_WR_FIFO_DEPTH,
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic [ADDR_W-1:0]   i_AVIn_Addr,
    input  logic [DATA_W/8-1:0] i_AVIn_ByteEn,
    input  logic                i_AVIn_Read,
    input  logic                i_AVIn_Write,
    input  logic [DATA_W-1:0]   i_AVIn_WriteData,
    output logic [DATA_W-1:0]   o_AVIn_ReadData,
    output logic                o_AVIn_WaitRequest,
    output logic [ADDR_W-1:0]   o_AVOut_Addr,
    output logic [DATA_W/8-1:0] o_AVOut_ByteEn,
    output logic                o_AVOut_Read,
    output logic                o_AVOut_Write,
    output logic [DATA_W-1:0]   o_AVOut_WriteData,
    input  logic [DATA_W-1:0]   i_AVOut_ReadData,
    input  logic                i_AVOut_WaitRequest
);

    localparam int BE_W    = DATA_W / 8;
    localparam int ENTRY_W = ADDR_W + BE_W + DATA_W;
    localparam int CNT_W   = $clog2(WR_FIFO_DEPTH) + 1;

    rd_state_t          state;
    rd_state_t          state_next;
    logic               latch_read;
    logic               capture_read;
    logic [ADDR_W-1:0]  rd_addr;
    logic [BE_W-1:0]    rd_byteen;
    logic [DATA_W-1:0]  rd_data;
    logic               rd_abort;

    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] fifo_next_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;

    logic [CNT_W-1:0]   count_after_pop;
    logic               wr_next;
    logic               rd_next;
    logic [ENTRY_W-1:0] present_entry;

    // A pending read blocks writes; a write is only taken while the FSM is idle.
    assign o_AVIn_WaitRequest = (i_AVIn_Read & (state != RD_DONE)) |
                                (i_AVIn_Write & ~i_AVIn_Read & (fifo_full | (state != IDLE)));

    assign push       = i_AVIn_Write & ~i_AVIn_Read & ~fifo_full & (state == IDLE);
    assign push_entry = {i_AVIn_Addr, i_AVIn_ByteEn, i_AVIn_WriteData};
    assign pop        = o_AVOut_Write & ~i_AVOut_WaitRequest;

    assign o_AVIn_ReadData = ((state == RD_DONE) && i_AVIn_Read && !rd_abort) ? rd_data : '0;

    av_wr_fifo #(
        .DEPTH (WR_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_wr_fifo (
        .i_Clk          (i_Clk),
        .i_Rst_n        (i_Rst_n),
        .push           (push),
        .push_data      (push_entry),
        .pop            (pop),
        .head_data      (fifo_head),
        .next_head_data (fifo_next_head),
        .count          (fifo_count),
        .full           (fifo_full),
        .empty          (fifo_empty)
    );

    always_comb begin
        state_next   = state;
        latch_read   = 1'b0;
        capture_read = 1'b0;
        case (state)
            IDLE: begin
                if (i_AVIn_Read) begin
                    latch_read = 1'b1;
                    state_next = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (fifo_empty && !o_AVOut_Write) begin
                    state_next = RD_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (o_AVOut_Read && !i_AVOut_WaitRequest) begin
                    capture_read = 1'b1;
                    state_next   = RD_DONE;
                end
            end
            RD_DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Downstream registers are loaded from the entry that will be the head after
    // this edge; a write pushed this cycle is presented one cycle later.
    always_comb begin
        count_after_pop = fifo_count - CNT_W'(pop);
        wr_next         = (count_after_pop != '0) &&
                          ((state_next == IDLE) || (state_next == RD_DRAIN));
        rd_next         = (state_next == RD_ISSUE);
        present_entry   = pop ? fifo_next_head : fifo_head;
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            state     <= IDLE;
            rd_addr   <= '0;
            rd_byteen <= '0;
            rd_data   <= '0;
            rd_abort  <= 1'b0;
        end else begin
            state <= state_next;
            if (latch_read) begin
                rd_addr   <= i_AVIn_Addr;
                rd_byteen <= i_AVIn_ByteEn;
                rd_abort  <= 1'b0;
            end else if (((state == RD_DRAIN) || (state == RD_ISSUE)) && !i_AVIn_Read) begin
                rd_abort <= 1'b1;
            end
            if (capture_read) begin
                rd_data <= i_AVOut_ReadData;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_AVOut_Read      <= 1'b0;
            o_AVOut_Write     <= 1'b0;
            o_AVOut_Addr      <= '0;
            o_AVOut_ByteEn    <= '0;
            o_AVOut_WriteData <= '0;
        end else begin
            o_AVOut_Read  <= rd_next;
            o_AVOut_Write <= wr_next;
            if (rd_next) begin
                o_AVOut_Addr   <= rd_addr;
                o_AVOut_ByteEn <= rd_byteen;
            end else if (wr_next) begin
                o_AVOut_Addr      <= present_entry[ENTRY_W-1 -: ADDR_W];
                o_AVOut_ByteEn    <= present_entry[DATA_W +: BE_W];
                o_AVOut_WriteData <= present_entry[DATA_W-1:0];
            end
        end
    end

endmodule
